crc_seq_ctrl: RTL and testbench

- Sequencing controller for the configurable bit-serial CRC datapath (`crc_comb` step: `data_in`, `crc_in`, `crc_poly`, `crc_poly_size` → `crc_out`).
- Accepts a framed stream of DATA_W-bit words over valid/ready and feeds them MSB-first, BITS_PER_CYCLE bits per clock, through an unrolled chain of CRC steps.
- Holds the running CRC register, latches configuration at frame start, and presents the final CRC with an output handshake.
- Sits between the bus/DMA front end and result registers of the CRC unit.

---
 rtl/crc_pkg.sv | 25 ++
 rtl/crc_comb.sv | 34 +++
 rtl/crc_step_unroll.sv | 37 +++
 rtl/crc_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_crc_seq_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC sequencing controller and its datapath.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package crc_pkg;

    localparam int                      CRC_SIZE_DEF = 8;
    localparam logic [CRC_SIZE_DEF-1:0] MASK_DEF     = 8'hff;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reverse the low 'width' bits of v; bits at and above 'width' come back as zero.
    function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_comb.sv
// Single bit-serial CRC step with a configurable polynomial and effective width.
// Latency: purely combinational.
// Backpressure: n/a.
module crc_comb #(
    parameter int                  CRC_SIZE = 8,
    parameter logic [CRC_SIZE-1:0] MASK     = '1
) (
    input  logic                data_in,
    input  logic [CRC_SIZE-1:0] crc_in,
    input  logic [CRC_SIZE-1:0] crc_poly,
    input  logic [CRC_SIZE-2:0] crc_poly_size,
    output logic [CRC_SIZE-1:0] crc_out
);

    int                  eff_w;
    logic                fb;
    logic [CRC_SIZE-1:0] width_mask;

    // Poly-size code 0 (or out of range) means full width; otherwise it is the CRC width.
    // MASK removes polynomial taps that are not configurable in this instance.
    always_comb begin
        eff_w = CRC_SIZE;
        if (crc_poly_size != '0 && int'(crc_poly_size) < CRC_SIZE) begin
            eff_w = int'(crc_poly_size);
        end
        width_mask = '0;
        for (int i = 0; i < CRC_SIZE; i++) begin
            width_mask[i] = (i < eff_w);
        end
        fb      = crc_in[eff_w-1] ^ data_in;
        crc_out = ({crc_in[CRC_SIZE-2:0], 1'b0} ^ ({CRC_SIZE{fb}} & crc_poly & MASK)) & width_mask;
    end

endmodule

// File: rtl/crc_step_unroll.sv
// Chain of BITS crc_comb steps; data_in[BITS-1] is consumed first.
// Latency: purely combinational.
// Backpressure: n/a.
module crc_step_unroll
    import crc_pkg::*;
#(
    parameter int                  CRC_SIZE = CRC_SIZE_DEF,
    parameter logic [CRC_SIZE-1:0] MASK     = MASK_DEF,
    parameter int                  BITS     = 8
) (
    input  logic [CRC_SIZE-1:0] crc_in,
    input  logic [CRC_SIZE-1:0] crc_poly,
    input  logic [CRC_SIZE-2:0] crc_poly_size,
    input  logic [BITS-1:0]     data_in,
    output logic [CRC_SIZE-1:0] crc_out
);

    logic [CRC_SIZE-1:0] chain [0:BITS];

    assign chain[0] = crc_in;

    for (genvar g = 0; g < BITS; g++) begin : g_step
        crc_comb #(
            .CRC_SIZE (CRC_SIZE),
            .MASK     (MASK)
        ) u_step (
            .data_in       (data_in[BITS-1-g]),
            .crc_in        (chain[g]),
            .crc_poly      (crc_poly),
            .crc_poly_size (crc_poly_size),
            .crc_out       (chain[g+1])
        );
    end

    assign crc_out = chain[BITS];

endmodule

// File: rtl/crc_seq_ctrl.sv
// Feeds framed DATA_W-bit words MSB-first, BITS_PER_CYCLE bits per clock, through the CRC chain.
// Latency: last word accepted at edge T -> crc_valid after edge T+STEPS (STEPS = DATA_W/BITS_PER_CYCLE).
// Backpressure: s_ready only while the current word is on its final step; DONE holds until crc_ready.
// Optional macro CRC_SEQ_REFLECT_EN adds cfg_reflect (LSB-first slices, bit-reversed result).
module crc_seq_ctrl
    import crc_pkg::*;
#(
    parameter int                  CRC_SIZE       = CRC_SIZE_DEF,
    parameter logic [CRC_SIZE-1:0] MASK           = MASK_DEF,
    parameter int                  DATA_W         = 32,
    parameter int                  BITS_PER_CYCLE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CRC_SIZE-1:0] cfg_poly,
    input  logic [CRC_SIZE-2:0] cfg_poly_size,
    input  logic [CRC_SIZE-1:0] cfg_init,
    input  logic [CRC_SIZE-1:0] cfg_xor_out,
`ifdef CRC_SEQ_REFLECT_EN
    input  logic                cfg_reflect,
`endif
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                crc_valid,
    input  logic                crc_ready,
    output logic [CRC_SIZE-1:0] crc_result,
    output logic                busy
);

    localparam int STEPS = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > DATA_W || (DATA_W % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("crc_seq_ctrl: DATA_W must be a multiple of BITS_PER_CYCLE, BITS_PER_CYCLE in 1..DATA_W");
    end

    state_t                    state, next_state;
    logic [CRC_SIZE-1:0]       crc_reg, poly_q, xor_q, step_crc, crc_final;
    logic [CRC_SIZE-2:0]       psize_q;
    logic [DATA_W-1:0]         shifter;
    logic [CNT_W-1:0]          cnt;
    logic                      have_word, last_seen, cnt_last, accept, reflect_q;
    logic [BITS_PER_CYCLE-1:0] slice, step_bits;

    assign cnt_last = (cnt == CNT_W'(STEPS - 1));
    assign accept   = s_valid && s_ready;
    assign slice    = shifter[DATA_W-1 -: BITS_PER_CYCLE];

`ifdef CRC_SEQ_REFLECT_EN
    // Reflection mode is part of the frame configuration, captured with the rest on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reflect_q <= 1'b0;
        end else if (state == IDLE && start) begin
            reflect_q <= cfg_reflect;
        end
    end
`else
    assign reflect_q = 1'b0;
`endif

    // Reflected mode feeds each slice LSB-first and reports the register bit-reversed.
    always_comb begin
        step_bits = slice;
        if (reflect_q) begin
            for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                step_bits[i] = slice[BITS_PER_CYCLE-1-i];
            end
        end
        crc_final = reflect_q ? CRC_SIZE'(bit_reverse(64'(crc_reg), CRC_SIZE)) : crc_reg;
    end

    crc_step_unroll #(
        .CRC_SIZE (CRC_SIZE),
        .MASK     (MASK),
        .BITS     (BITS_PER_CYCLE)
    ) u_unroll (
        .crc_in        (crc_reg),
        .crc_poly      (poly_q),
        .crc_poly_size (psize_q),
        .data_in       (step_bits),
        .crc_out       (step_crc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state: a frame ends on the final step of the word flagged last.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (have_word && cnt_last && last_seen) next_state = DONE;
            DONE:    if (crc_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: ready on the last step of a word so back-to-back words leave no bubble.
    always_comb begin
        s_ready    = 1'b0;
        crc_valid  = 1'b0;
        busy       = 1'b0;
        crc_result = '0;
        case (state)
            RUN: begin
                s_ready = !last_seen && (!have_word || cnt_last);
                busy    = 1'b1;
            end
            DONE: begin
                crc_valid  = 1'b1;
                busy       = 1'b1;
                crc_result = crc_final ^ xor_q;
            end
            default: ;
        endcase
    end

    // Datapath: config capture on start, per-cycle CRC advance and word loading in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg   <= '0;
            poly_q    <= '0;
            psize_q   <= '0;
            xor_q     <= '0;
            shifter   <= '0;
            cnt       <= '0;
            have_word <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        poly_q    <= cfg_poly;
                        psize_q   <= cfg_poly_size;
                        xor_q     <= cfg_xor_out;
                        crc_reg   <= cfg_init;
                        cnt       <= '0;
                        have_word <= 1'b0;
                        last_seen <= 1'b0;
                    end
                end
                RUN: begin
                    if (have_word) begin
                        crc_reg <= step_crc;
                        shifter <= shifter << BITS_PER_CYCLE;
                        cnt     <= cnt + 1'b1;
                    end
                    // A new word overrides the shift/count of a word finishing this cycle.
                    if (accept) begin
                        shifter   <= s_data;
                        cnt       <= '0;
                        have_word <= 1'b1;
                        last_seen <= s_last;
                    end else if (have_word && cnt_last) begin
                        have_word <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_seq_ctrl.sv
module tb_crc_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] cfg_poly, cfg_init, cfg_xor_out;
    logic [6:0] cfg_poly_size;
    logic       crc_ready;
`ifdef CRC_SEQ_REFLECT_EN
    logic       cfg_reflect;
`endif

    // Instance a: DATA_W=8, one word per cycle.
    logic       a_start, a_valid, a_ready, a_last, a_crc_valid, a_busy;
    logic [7:0] a_data, a_result;
    // Instance b: DATA_W=32, four cycles per word.
    logic        b_start, b_valid, b_ready, b_last, b_crc_valid, b_busy;
    logic [31:0] b_data;
    logic [7:0]  b_result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [31:0] model_words[$];
    logic [7:0]  held_b;

    crc_seq_ctrl #(.CRC_SIZE(8), .MASK(8'hff), .DATA_W(8), .BITS_PER_CYCLE(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start),
        .cfg_poly(cfg_poly), .cfg_poly_size(cfg_poly_size), .cfg_init(cfg_init), .cfg_xor_out(cfg_xor_out),
`ifdef CRC_SEQ_REFLECT_EN
        .cfg_reflect(cfg_reflect),
`endif
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_last(a_last),
        .crc_valid(a_crc_valid), .crc_ready(crc_ready), .crc_result(a_result), .busy(a_busy)
    );

    crc_seq_ctrl #(.CRC_SIZE(8), .MASK(8'hff), .DATA_W(32), .BITS_PER_CYCLE(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start),
        .cfg_poly(cfg_poly), .cfg_poly_size(cfg_poly_size), .cfg_init(cfg_init), .cfg_xor_out(cfg_xor_out),
`ifdef CRC_SEQ_REFLECT_EN
        .cfg_reflect(cfg_reflect),
`endif
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_last(b_last),
        .crc_valid(b_crc_valid), .crc_ready(crc_ready), .crc_result(b_result), .busy(b_busy)
    );

    // Bit-serial reference over model_words, 8-bit slices from the top of each dw-bit word.
    function automatic logic [7:0] model_crc(input logic [7:0] init, input logic [7:0] poly,
                                             input logic [7:0] xo, input int dw, input bit refl);
        logic [7:0] crc, sl, r;
        logic       fb, bt;
        crc = init;
        foreach (model_words[k]) begin
            for (int s = dw / 8 - 1; s >= 0; s--) begin
                sl = model_words[k][s*8 +: 8];
                for (int b = 0; b < 8; b++) begin
                    bt  = refl ? sl[b] : sl[7-b];
                    fb  = crc[7] ^ bt;
                    crc = {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
                end
            end
        end
        r = crc;
        if (refl) for (int i = 0; i < 8; i++) r[i] = crc[7-i];
        return r ^ xo;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic l);
        a_valid = 1'b1; a_data = d; a_last = l;
        for (int c = 0; c < 20 && !a_ready; c++) tick();
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_a timeout: s_ready=%b, required 1", a_ready);
        end
        tick();
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        b_valid = 1'b1; b_data = d; b_last = l;
        for (int c = 0; c < 20 && !b_ready; c++) tick();
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_b timeout: s_ready=%b, required 1", b_ready);
        end
        tick();
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic release_result();
        crc_ready = 1'b1;
        tick();
        crc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_start = 0; a_valid = 0; a_last = 0; a_data = '0;
        b_start = 0; b_valid = 0; b_last = 0; b_data = '0;
        cfg_poly = 8'h07; cfg_init = 8'h00; cfg_xor_out = 8'h00; cfg_poly_size = '0; crc_ready = 1'b0;
`ifdef CRC_SEQ_REFLECT_EN
        cfg_reflect = 1'b0;
`endif
        #22;
        n_checks++;
        if ({a_ready, a_crc_valid, a_busy, a_result} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_a: got rdy/vld/busy/res=%b/%b/%b/%h, required all 0", a_ready, a_crc_valid, a_busy, a_result);
        end
        n_checks++;
        if ({b_ready, b_crc_valid, b_busy, b_result} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_b: got rdy/vld/busy/res=%b/%b/%b/%h, required all 0", b_ready, b_crc_valid, b_busy, b_result);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_check_value();
        cfg_poly = 8'h07; cfg_init = 8'h00; cfg_xor_out = 8'h00;
        model_words.delete();
        for (int i = 0; i < 9; i++) model_words.push_back(32'(8'h31 + i));
        exp_a.push_back(model_crc(8'h00, 8'h07, 8'h00, 8, 1'b0));
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 9; i++) send_a(8'(8'h31 + i), i == 8);
        n_checks++;
        if (a_crc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL check_early_valid: crc_valid=%b at accept, required 0", a_crc_valid);
        end
        tick();
        n_checks++;
        if (a_crc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL check_latency: crc_valid=%b one cycle after last accept, required 1", a_crc_valid);
        end
        n_checks++;
        if (a_result !== 8'hF4) begin
            n_fail++;
            $display("FAIL check_value: crc_result=%h, required f4", a_result);
        end
        n_checks++;
        if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL check_sb: scoreboard empty, crc_result=%h", a_result);
        end else if (a_result !== exp_a[0]) begin
            n_fail++;
            $display("FAIL check_sb: crc_result=%h, required %h", a_result, exp_a.pop_front());
        end else void'(exp_a.pop_front());
        release_result();
        n_checks++;
        if ({a_crc_valid, a_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL check_release: vld/busy=%b/%b, required 0/0", a_crc_valid, a_busy);
        end
    endtask

    task automatic test_throughput();
        logic [31:0] w[3];
        int          acc_cyc[3];
        int          idx, ready_cnt;
        cfg_poly = 8'h07; cfg_init = 8'h00; cfg_xor_out = 8'h5A;
        model_words.delete();
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            model_words.push_back(w[i]);
            acc_cyc[i] = -100;
        end
        exp_b.push_back(model_crc(8'h00, 8'h07, 8'h5A, 32, 1'b0));
        b_start = 1'b1; tick(); b_start = 1'b0;
        idx = 0; ready_cnt = 0;
        b_valid = 1'b1; b_data = w[0]; b_last = 1'b0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            if (b_ready) begin
                ready_cnt++;
                acc_cyc[idx] = c;
                idx++;
                tick();
                if (idx < 3) begin
                    b_data = w[idx];
                    b_last = (idx == 2);
                end else begin
                    b_valid = 1'b0;
                    b_last  = 1'b0;
                end
            end else begin
                tick();
            end
        end
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
            n_fail++;
            $display("FAIL tput_spacing: accepts at %0d,%0d,%0d, required spacing 4", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_checks++;
        if (ready_cnt != 3) begin
            n_fail++;
            $display("FAIL tput_ready_count: s_ready high %0d cycles, required 3", ready_cnt);
        end
        tick(); tick(); tick();
        n_checks++;
        if (b_crc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tput_early_valid: crc_valid=%b 3 cycles after last accept, required 0", b_crc_valid);
        end
        tick();
        n_checks++;
        if (b_crc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tput_latency: crc_valid=%b 4 cycles after last accept, required 1", b_crc_valid);
        end
        n_checks++;
        held_b = 8'h00;
        if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL tput_result: scoreboard empty, crc_result=%h", b_result);
        end else begin
            held_b = exp_b.pop_front();
            if (b_result !== held_b) begin
                n_fail++;
                $display("FAIL tput_result: crc_result=%h, required %h", b_result, held_b);
            end
        end
    endtask

    task automatic test_backpressure();
        crc_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                cfg_poly = 8'h31; cfg_xor_out = 8'hFF; b_start = 1'b1;
            end
            tick();
            b_start = 1'b0;
            n_checks++;
            if ({b_crc_valid, b_result} !== {1'b1, held_b}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld/res=%b/%h, required 1/%h", c, b_crc_valid, b_result, held_b);
            end
        end
        cfg_poly = 8'h07; cfg_xor_out = 8'h00;
        release_result();
        n_checks++;
        if ({b_crc_valid, b_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_release: vld/busy=%b/%b, required 0/0", b_crc_valid, b_busy);
        end
    endtask

    task automatic test_config_latch();
        logic [31:0] w0, w1;
        int          waited;
        w0 = $urandom; w1 = $urandom;
        cfg_poly = 8'h07; cfg_init = 8'h3C; cfg_xor_out = 8'h00;
        model_words.delete();
        model_words.push_back(w0); model_words.push_back(w1);
        exp_b.push_back(model_crc(8'h3C, 8'h07, 8'h00, 32, 1'b0));
        b_start = 1'b1; tick(); b_start = 1'b0;
        send_b(w0, 1'b0);
        cfg_poly = 8'h31; cfg_init = 8'h99; cfg_xor_out = 8'h0F;
        send_b(w1, 1'b1);
        waited = 0;
        while (!b_crc_valid && waited < 12) begin
            tick();
            waited++;
        end
        n_checks++;
        if (b_crc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_timeout: crc_valid=%b after %0d cycles, required 1", b_crc_valid, waited);
        end
        n_checks++;
        if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL cfg_latch: scoreboard empty, crc_result=%h", b_result);
        end else if (b_result !== exp_b[0]) begin
            n_fail++;
            $display("FAIL cfg_latch: crc_result=%h, required %h", b_result, exp_b.pop_front());
        end else void'(exp_b.pop_front());
        release_result();
        cfg_poly = 8'h07; cfg_init = 8'h00; cfg_xor_out = 8'h00;
    endtask

    task automatic test_reset_midframe();
        b_start = 1'b1; tick(); b_start = 1'b0;
        send_b(32'hDEADBEEF, 1'b1);
        tick();
        n_checks++;
        if (b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_busy: busy=%b mid-word, required 1", b_busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({b_ready, b_crc_valid, b_busy, b_result} !== 11'h0) begin
            n_fail++;
            $display("FAIL rst_midframe: rdy/vld/busy/res=%b/%b/%b/%h, required all 0", b_ready, b_crc_valid, b_busy, b_result);
        end
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        n_checks++;
        if ({b_crc_valid, b_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_abort: vld/busy=%b/%b after reset, required 0/0", b_crc_valid, b_busy);
        end
        // New frame on instance a; a word offered alongside start must be ignored.
        cfg_poly = 8'h07; cfg_init = 8'hFF; cfg_xor_out = 8'h00;
        model_words.delete();
        model_words.push_back(32'h0);
        exp_a.push_back(model_crc(8'hFF, 8'h07, 8'h00, 8, 1'b0));
        a_start = 1'b1; a_valid = 1'b1; a_data = 8'hAA;
        n_checks++;
        if (a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: s_ready=%b in IDLE, required 0", a_ready);
        end
        tick();
        a_start = 1'b0; a_valid = 1'b0;
        send_a(8'h00, 1'b1);
        tick();
        n_checks++;
        if ({a_crc_valid, a_result} !== {1'b1, 8'hF3}) begin
            n_fail++;
            $display("FAIL rst_next_frame: vld/res=%b/%h, required 1/f3", a_crc_valid, a_result);
        end
        n_checks++;
        if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL rst_next_sb: scoreboard empty, crc_result=%h", a_result);
        end else if (a_result !== exp_a[0]) begin
            n_fail++;
            $display("FAIL rst_next_sb: crc_result=%h, required %h", a_result, exp_a.pop_front());
        end else void'(exp_a.pop_front());
        release_result();
        cfg_init = 8'h00;
    endtask

`ifdef CRC_SEQ_REFLECT_EN
    task automatic test_reflect();
        cfg_poly = 8'h07; cfg_init = 8'hFF; cfg_xor_out = 8'h00; cfg_reflect = 1'b1;
        model_words.delete();
        for (int i = 0; i < 9; i++) model_words.push_back(32'(8'h31 + i));
        exp_a.push_back(model_crc(8'hFF, 8'h07, 8'h00, 8, 1'b1));
        a_start = 1'b1; tick(); a_start = 1'b0; cfg_reflect = 1'b0;
        for (int i = 0; i < 9; i++) send_a(8'(8'h31 + i), i == 8);
        tick();
        n_checks++;
        if ({a_crc_valid, a_result} !== {1'b1, 8'hD0}) begin
            n_fail++;
            $display("FAIL reflect_value: vld/res=%b/%h, required 1/d0", a_crc_valid, a_result);
        end
        n_checks++;
        if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL reflect_sb: scoreboard empty, crc_result=%h", a_result);
        end else if (a_result !== exp_a[0]) begin
            n_fail++;
            $display("FAIL reflect_sb: crc_result=%h, required %h", a_result, exp_a.pop_front());
        end else void'(exp_a.pop_front());
        release_result();
        cfg_init = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_check_value();
        test_throughput();
        test_backpressure();
        test_config_latch();
        test_reset_midframe();
`ifdef CRC_SEQ_REFLECT_EN
        test_reflect();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
